// File: rtl/gb_dma_pkg.sv
// Shared types and constants for the Game Boy OAM DMA controller.
// The optional echo-page remap is selected with OAM_DMA_ECHO_MAP_EN.
package gb_dma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        ACTIVE
    } dma_state_e;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] HRAM_LO      = 16'hFF80;
    localparam logic [15:0] HRAM_HI      = 16'hFFFE;

    localparam int unsigned OAM_LEN_DEFAULT   = 160;
    localparam int unsigned BYTE_CLKS_DEFAULT = 4;

    // Pages $E0..$FF alias work RAM, so the copy is sourced from $C0..$DF.
    function automatic logic [7:0] echo_map(input logic [7:0] page);
        return (page >= 8'hE0) ? (page - 8'h20) : page;
    endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU register port, source-read port and OAM write port of the OAM DMA controller.
// master is the controller side, slave is the surrounding system side.
interface oam_dma_ctrl_if;

    logic        cpu_sel;
    logic        cpu_wr;
    logic [7:0]  cpu_di;
    logic [7:0]  cpu_do;
    logic        dma_active;
    logic        dma_rd;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data;
    logic        oam_wr;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;

    modport master (
        input  cpu_sel, cpu_wr, cpu_di, dma_data,
        output cpu_do, dma_active, dma_rd, dma_addr, oam_wr, oam_addr, oam_data
    );

    modport slave (
        output cpu_sel, cpu_wr, cpu_di, dma_data,
        input  cpu_do, dma_active, dma_rd, dma_addr, oam_wr, oam_addr, oam_data
    );

endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a write to $FF46 copies OAM_LEN bytes from page {value,8'h00} into OAM.
// Define OAM_DMA_ECHO_MAP_EN to remap source pages >= $E0 down by $20.
module oam_dma_ctrl
    import gb_dma_pkg::*;
#(
    parameter int unsigned BYTE_CLKS = BYTE_CLKS_DEFAULT,
    parameter int unsigned OAM_LEN   = OAM_LEN_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    oam_dma_ctrl_if.master   bus
);

    localparam int unsigned PW = (BYTE_CLKS > 1) ? $clog2(BYTE_CLKS) : 1;
    localparam logic [PW-1:0] PH_ZERO = '0;
    localparam logic [PW-1:0] PH_ONE  = PW'(1);
    localparam logic [PW-1:0] PH_LAST = PW'(BYTE_CLKS - 1);
    localparam logic [7:0]    IDX_LAST = 8'(OAM_LEN - 1);

    dma_state_e    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    page_q, page_d;
    logic [7:0]    cpu_do_q, cpu_do_d;
    logic          wr_q;
    logic          start;
    logic [7:0]    src_page;

    logic          active_q, active_d;
    logic          rd_q, rd_d;
    logic [15:0]   addr_q, addr_d;
    logic          oam_wr_q, oam_wr_d;
    logic [7:0]    oam_addr_q, oam_addr_d;

`ifdef OAM_DMA_ECHO_MAP_EN
    assign src_page = echo_map(bus.cpu_di);
`else
    assign src_page = bus.cpu_di;
`endif

    // A held write strobe starts only one transfer.
    assign start = bus.cpu_sel && bus.cpu_wr && !wr_q;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        idx_d    = idx_q;
        page_d   = page_q;
        cpu_do_d = cpu_do_q;

        unique case (state_q)
            IDLE: begin
                phase_d = PH_ZERO;
                idx_d   = 8'h00;
            end
            START: begin
                if (phase_q == PH_LAST) begin
                    state_d = ACTIVE;
                    phase_d = PH_ZERO;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            ACTIVE: begin
                if (phase_q == PH_ONE && idx_q == IDX_LAST) begin
                    state_d = IDLE;
                    phase_d = PH_ZERO;
                    idx_d   = 8'h00;
                end else if (phase_q == PH_LAST) begin
                    phase_d = PH_ZERO;
                    idx_d   = idx_q + 8'd1;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = PH_ZERO;
                idx_d   = 8'h00;
            end
        endcase

        // Start or restart overrides the sequencing above from any state.
        if (start) begin
            state_d  = START;
            phase_d  = PH_ZERO;
            idx_d    = 8'h00;
            page_d   = src_page;
            cpu_do_d = bus.cpu_di;
        end

        // Outputs are decoded from the next state so they appear registered.
        active_d   = (state_d != IDLE);
        rd_d       = (state_d == ACTIVE) && (phase_d == PH_ZERO);
        oam_wr_d   = (state_d == ACTIVE) && (phase_d == PH_ONE);
        addr_d     = rd_d ? {page_d, idx_d} : addr_q;
        oam_addr_d = oam_wr_d ? idx_d : oam_addr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            phase_q    <= PH_ZERO;
            idx_q      <= 8'h00;
            page_q     <= 8'h00;
            cpu_do_q   <= 8'hFF;
            wr_q       <= 1'b0;
            active_q   <= 1'b0;
            rd_q       <= 1'b0;
            addr_q     <= 16'h0000;
            oam_wr_q   <= 1'b0;
            oam_addr_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            page_q     <= page_d;
            cpu_do_q   <= cpu_do_d;
            wr_q       <= bus.cpu_sel && bus.cpu_wr;
            active_q   <= active_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            oam_wr_q   <= oam_wr_d;
            oam_addr_q <= oam_addr_d;
        end
    end

    assign bus.cpu_do     = cpu_do_q;
    assign bus.dma_active = active_q;
    assign bus.dma_rd     = rd_q;
    assign bus.dma_addr   = addr_q;
    assign bus.oam_wr     = oam_wr_q;
    assign bus.oam_addr   = oam_addr_q;
    // Source RAM data lands in the oam_wr clock, so it is passed straight through.
    assign bus.oam_data   = oam_wr_q ? bus.dma_data : 8'h00;

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

OAM DMA controller for the Game Boy core. It is triggered by a CPU write to $FF46 and copies OAM_LEN bytes from page `{value,8'h00}` into sprite attribute memory. While a copy runs it owns the cart/iram/vram read path, and it signals the top level to fence the CPU to high RAM. It sits beside `video`: it drives the source-read mux and the OAM write port.

## Interface
Parameters:
- BYTE_CLKS, 4, clocks per transferred byte; minimum 2.
- OAM_LEN, 160, bytes per transfer; 1..256.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- cpu_sel  in  1  CPU address decodes to $FF46.
- cpu_wr  in  1  CPU write strobe, level; may stay high several clocks.
- cpu_di  in  8  CPU write data (source page).
- cpu_do  out  8  readback of last written page.
- dma_active  out  1  transfer in progress; top level returns $FF for CPU reads outside $FF80–$FFFE.
- dma_rd  out  1  source read strobe, one clock per byte.
- dma_addr  out  16  source address.
- dma_data  in  8  source data, valid the clock after dma_rd (synchronous RAM).
- oam_wr  out  1  OAM write strobe, one clock.
- oam_addr  out  8  OAM byte index.
- oam_data  out  8  OAM write data.

## Operation
- Start event: the rising edge of (cpu_sel && cpu_wr), registered on the previous clock. A held write counts once.
- On a start event: latch cpu_di into page and cpu_do, then go to START, idx=0, phase=0.
- States:
  - IDLE: all strobes 0, dma_active 0.
  - START: dma_active 1, no strobes. Lasts BYTE_CLKS clocks, then go to ACTIVE.
  - ACTIVE: phase counts 0..BYTE_CLKS-1.
    - Phase 0: dma_rd=1, dma_addr={src_page,idx}.
    - Phase 1: oam_wr=1, oam_addr=idx, oam_data=dma_data.
    - At phase BYTE_CLKS-1: idx++.
    - After the oam_wr for idx=OAM_LEN-1, go to IDLE on the next clock.
- Restart: a start event in START or ACTIVE reloads page and goes to START with idx=0. dma_active stays 1 throughout, with no gap.
- Outputs are registered. On the clock a restart is sampled, an already-presented strobe completes; no further strobe for the old page is issued.
- Reset mid-transfer: the next state is IDLE. OAM keeps partially written contents.
- Arithmetic: idx is 8 bits and never wraps; the terminal compare uses OAM_LEN-1. phase width is $clog2(BYTE_CLKS).
- Writes to $FF46 during a transfer always update cpu_do.

## Timing
- Reset values: cpu_do=8'hFF, dma_active=0, dma_rd=0, dma_addr=0, oam_wr=0, oam_addr=0, oam_data=0; state IDLE.
- Write sampled at clock T: dma_active=1 from T+1.
- Byte i read at R_i = T+1+BYTE_CLKS*(1+i); oam_wr at R_i+1.
- With defaults: first dma_rd at T+5, last oam_wr at T+642, dma_active=0 from T+643.
- dma_rd and oam_wr are never high in the same clock.

## Configuration
- OAM_DMA_ECHO_MAP_EN.
  - Defined: a page ≥ 8'hE0 is mapped to page-8'h20, so echo/FE/FF pages source $C000–$DFFF. cpu_do still returns the unmapped written value.
  - Undefined: src_page = written page unchanged.

## Structure
- Shared package gb_dma_pkg:
  - state enum {IDLE, START, ACTIVE};
  - DMA_REG_ADDR=16'hFF46;
  - HRAM_LO=16'hFF80, HRAM_HI=16'hFFFE;
  - default OAM_LEN.
- Flat module, no sub-modules; edge detect, phase and index counters live inline.

## Test plan
- Write $C1 with defaults, source returns addr[7:0]^$5A.
  - Required: 160 oam_wr at T+6+4i, oam_addr=i, oam_data=i^$5A; dma_addr $C100..$C19F.
  - dma_active high T+1..T+642.
- cpu_wr held 6 clocks with cpu_sel.
  - Required: exactly one transfer.
  - cpu_do=$C1 after the write; reads $FF after reset.
- Restart: write $C0, then write $D0 at T+100.
  - Required: dma_active never drops; next dma_rd address $D000 at T+105.
  - 160 further writes; no $C0xx read after T+100.
- Reset asserted at T+50 for one clock.
  - Required: next clock all outputs at reset values; no strobes until a new write.
- OAM_DMA_ECHO_MAP_EN defined, write $E3.
  - Required: dma_addr $C300..$C39F; cpu_do=$E3.
  - Undefined: dma_addr $E300..$E39F.
- BYTE_CLKS=2, OAM_LEN=4, write $80 at T.
  - Required: dma_rd at T+3,5,7,9; oam_wr at T+4,6,8,10; dma_active low from T+11.
